// File: rtl/xy_waypoint_sched.sv
// xy_waypoint_sched: FIFO-fed waypoint sequencer driving the XY positioner target/motion pins.
// Define XY_SCHED_TIMEOUT_EN to add a sticky MOVE timeout that drops the stuck waypoint.
module xy_waypoint_sched #(
    parameter int DEPTH      = 4,
    parameter int DWELL_W    = 4,
    parameter int MIN_SETTLE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wp_valid,
    input  logic [7:0]               wp_data,
    output logic                     wp_ready,
    input  logic                     abort,
    input  logic [DWELL_W-1:0]       dwell_cycles,
    input  logic [3:0]               x_pos,
    input  logic [3:0]               y_pos,
    output logic [7:0]               target_out,
    output logic                     motion,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef XY_SCHED_TIMEOUT_EN
    ,
    output logic                     timeout
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef XY_SCHED_TIMEOUT_EN
    localparam int MW = 6;
`else
    localparam int MW = $clog2(MIN_SETTLE + 1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, MOVE, DWELL} state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [MW-1:0]      move_cnt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cap;
    logic               push, pop, more, arrive;

    assign wp_ready   = count != CW'(DEPTH);
    assign fifo_count = count;
    assign push       = wp_valid && wp_ready && !abort;
    assign pop        = state == LOAD && !abort;
    assign more       = count != '0;
    // move_cnt lags by one, so this accepts arrival in the MIN_SETTLE-th MOVE cycle
    assign arrive     = move_cnt >= MW'(MIN_SETTLE - 1) && x_pos == target_out[7:4] && y_pos == target_out[3:0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wp_data;
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            target_out <= '0;
            motion     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_cnt   <= '0;
            dwell_cnt  <= '0;
            dwell_cap  <= '0;
`ifdef XY_SCHED_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else if (abort) begin
            state  <= IDLE;
            motion <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef XY_SCHED_TIMEOUT_EN
            timeout <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (more) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    target_out <= mem[rd_ptr];
                    move_cnt   <= '0;
                    motion     <= 1'b1;
                    state      <= MOVE;
                end
                MOVE: begin
                    move_cnt <= (&move_cnt) ? move_cnt : move_cnt + 1'b1;
                    if (arrive) begin
                        state     <= DWELL;
                        motion    <= 1'b0;
                        dwell_cap <= dwell_cycles;
                        dwell_cnt <= '0;
                    end
`ifdef XY_SCHED_TIMEOUT_EN
                    else if (move_cnt == MW'(62)) begin
                        timeout <= 1'b1;
                        motion  <= 1'b0;
                        state   <= more ? LOAD : IDLE;
                        busy    <= more;
                    end
`endif
                end
                DWELL: if (dwell_cnt == dwell_cap) begin
                    done  <= 1'b1;
                    state <= more ? LOAD : IDLE;
                    busy  <= more;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xy_waypoint_sched.sv
// tb_xy_waypoint_sched: directed vectors, corner sequences and random traffic
// checked every cycle against a queue-based reference of the scheduler.
module tb_xy_waypoint_sched;
    localparam int DEPTH = 4, DWELL_W = 4, MIN_SETTLE = 4;

    logic clk = 0, reset = 1, wp_valid = 0, abort = 0;
    logic [7:0] wp_data = 0;
    logic [DWELL_W-1:0] dwell_cycles = 0;
    logic [3:0] x_pos = 0, y_pos = 0;
    logic wp_ready, motion, busy, done;
    logic [7:0] target_out;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef XY_SCHED_TIMEOUT_EN
    logic timeout;
`endif

    int errors = 0, checks = 0;
    bit track = 0;

    always #5 clk = ~clk;

    xy_waypoint_sched #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .MIN_SETTLE(MIN_SETTLE)) dut (
        .clk(clk), .reset(reset), .wp_valid(wp_valid), .wp_data(wp_data), .wp_ready(wp_ready),
        .abort(abort), .dwell_cycles(dwell_cycles), .x_pos(x_pos), .y_pos(y_pos),
        .target_out(target_out), .motion(motion), .busy(busy), .done(done), .fifo_count(fifo_count)
`ifdef XY_SCHED_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of pending waypoints plus phase 0 idle, 1 load, 2 move, 3 dwell.
    logic [7:0] q[$];
    logic [7:0] m_tgt = 0;
    int ph = 0, moved = 0, left = 0, n = 0;
    bit m_done = 0;

    initial forever begin
        @(posedge clk);
        if (reset || abort) begin
            q.delete();
            ph = 0;
            m_done = 0;
            if (reset) m_tgt = 0;
        end else begin
            n = q.size();
            m_done = 0;
            if (ph == 0) ph = n > 0 ? 1 : 0;
            else if (ph == 1) begin
                m_tgt = q.pop_front();
                moved = 0;
                ph = 2;
            end else if (ph == 2) begin
                moved++;
                if (moved >= MIN_SETTLE && {x_pos, y_pos} == m_tgt) begin
                    ph = 3;
                    left = int'(dwell_cycles);
                end
            end else if (left == 0) begin
                m_done = 1;
                ph = n > 0 ? 1 : 0;
            end else left--;
            if (wp_valid && n < DEPTH) q.push_back(wp_data);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("m_target", target_out, m_tgt);
        chk("m_motion", motion, int'(ph == 2));
        chk("m_busy", busy, int'(ph != 0));
        chk("m_done", done, int'(m_done));
        chk("m_count", fifo_count, q.size());
        chk("m_ready", wp_ready, int'(q.size() < DEPTH));
        if (track) {x_pos, y_pos} = target_out;
    end

    typedef struct {
        logic [7:0] wp;
        int dwell;
        int t;
        int exp_move;
        int exp_dwell;
    } vec_t;
    vec_t tbl[5];
    logic [7:0] expq[$];

    task automatic push(input logic [7:0] d);
        wp_data = d;
        wp_valid = 1;
        @(negedge clk);
        wp_valid = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int mv, dw;
        {x_pos, y_pos} = v.t == 0 ? v.wp : v.wp ^ 8'h11;
        dwell_cycles = DWELL_W'(v.dwell);
        push(v.wp);
        chk("vec_count", fifo_count, 1);
        @(negedge clk);
        chk("vec_load_motion", motion, 0);
        @(negedge clk);
        chk("vec_target", target_out, v.wp);
        chk("vec_motion", motion, 1);
        mv = 0;
        while (motion && mv < 100) begin
            mv++;
            if (mv == v.t) {x_pos, y_pos} = v.wp;
            @(negedge clk);
        end
        chk("vec_move_cycles", mv, v.exp_move);
        dw = 0;
        while (!done && dw < 100) begin
            dw++;
            @(negedge clk);
        end
        chk("vec_dwell_cycles", dw, v.exp_dwell);
        chk("vec_busy_end", busy, 0);
        chk("vec_count_end", fifo_count, 0);
        @(negedge clk);
        chk("vec_done_once", done, 0);
    endtask

    task automatic serve(input string tag, input int exp_done);
        logic [7:0] got[$];
        int dn, k;
        logic pm;
        dn = 0;
        k = 0;
        pm = motion;
        while ((busy || fifo_count != 0) && k < 400) begin
            @(negedge clk);
            k++;
            if (motion && !pm) got.push_back(target_out);
            if (done) dn++;
            pm = motion;
        end
        chk({tag, "_drain"}, int'(k < 400), 1);
        chk({tag, "_dones"}, dn, exp_done);
        chk({tag, "_served"}, got.size(), expq.size());
        foreach (expq[i]) chk({tag, "_order"}, i < got.size() ? int'(got[i]) : -1, expq[i]);
    endtask

    initial begin
        int k;
        tbl[0] = '{8'h35, 2, 6, 6, 3};
        tbl[1] = '{8'h00, 0, 0, 4, 1};
        tbl[2] = '{8'hAF, 15, 3, 4, 16};
        tbl[3] = '{8'h99, 5, 10, 10, 6};
        tbl[4] = '{8'hFF, 1, 5, 5, 2};

        repeat (2) @(negedge clk);
        chk("rst_target", target_out, 0);
        chk("rst_motion", motion, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", wp_ready, 1);
        reset = 0;
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Fill the FIFO behind a waypoint stuck in MOVE, then offer one more.
        {x_pos, y_pos} = 8'h00;
        dwell_cycles = 1;
        push(8'h11);
        repeat (2) @(negedge clk);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        chk("full_count", fifo_count, 4);
        chk("full_ready", wp_ready, 0);
        wp_data = 8'h66;
        wp_valid = 1;
        repeat (2) begin
            @(negedge clk);
            chk("full_reject", fifo_count, 4);
        end
        wp_valid = 0;
        expq = '{8'h22, 8'h33, 8'h44, 8'h55};
        track = 1;
        serve("full", 5);
        track = 0;

        // Push lands in the same cycle as the LOAD pop.
        {x_pos, y_pos} = 8'h00;
        dwell_cycles = 0;
        push(8'hA1);
        repeat (2) @(negedge clk);
        push(8'hB2);
        push(8'hC3);
        chk("pp_count_pre", fifo_count, 2);
        {x_pos, y_pos} = 8'hA1;
        k = 0;
        while (!done && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("pp_done", done, 1);
        push(8'hD4);
        chk("pp_count", fifo_count, 2);
        chk("pp_target", target_out, 8'hB2);
        expq = '{8'hC3, 8'hD4};
        track = 1;
        serve("pp", 3);
        track = 0;

        // Abort mid-MOVE with two queued and a simultaneous push.
        {x_pos, y_pos} = 8'h00;
        push(8'hE5);
        repeat (2) @(negedge clk);
        push(8'hF6);
        push(8'h07);
        chk("ab_count_pre", fifo_count, 2);
        chk("ab_motion_pre", motion, 1);
        abort = 1;
        wp_valid = 1;
        wp_data = 8'h88;
        @(negedge clk);
        abort = 0;
        wp_valid = 0;
        chk("ab_motion", motion, 0);
        chk("ab_count", fifo_count, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_target", target_out, 8'hE5);
        repeat (4) begin
            @(negedge clk);
            chk("ab_stay_idle", busy, 0);
            chk("ab_no_done", done, 0);
        end

        for (int c = 0; c < 4000; c++) begin
            reset = (c == 2000);
            wp_valid = $urandom_range(0, 9) < 4;
            wp_data = 8'($urandom);
            abort = $urandom_range(0, 99) == 0;
            dwell_cycles = DWELL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                {x_pos, y_pos} = $urandom_range(0, 1) ? m_tgt : 8'($urandom);
            @(negedge clk);
        end
        reset = 0;
        abort = 0;
        wp_valid = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
